// File: rtl/t5_pkg.sv
// Shared constants and lane payload types for the t5 lane-logic pipeline.
package t5_pkg;

  localparam int unsigned PI_PER_LANE = 5;
  localparam int unsigned PO_PER_LANE = 2;

  localparam int unsigned LANES_MIN = 1;
  localparam int unsigned LANES_MAX = 16;
  localparam int unsigned DEPTH_MIN = 1;
  localparam int unsigned DEPTH_MAX = 4;
  localparam int unsigned CNT_W_MIN = 4;
  localparam int unsigned CNT_W_MAX = 16;

  typedef struct packed {
    logic pi4;
    logic pi3;
    logic pi2;
    logic pi1;
    logic pi0;
  } lane_pi_t;

  typedef struct packed {
    logic po1;
    logic po0;
  } lane_po_t;

endpackage

// File: rtl/t5_lane.sv
// Combinational logic for one lane: five inputs reduced to po0/po1.
module t5_lane
  import t5_pkg::*;
(
  input  lane_pi_t i_pi,
  output lane_po_t o_po_c
);

  logic w_n9;

  always_comb begin
    w_n9       = i_pi.pi2 & i_pi.pi3;
    o_po_c.po0 = (i_pi.pi0 & i_pi.pi2) | (i_pi.pi1 & ~w_n9);
    o_po_c.po1 = ~w_n9 & (i_pi.pi1 | i_pi.pi4);
  end

endmodule

// File: rtl/t5_pipe.sv
// Elastic DEPTH-stage pipeline of lane results plus a saturating counter of delivered po1 bits.
module t5_pipe
  import t5_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PI_PER_LANE*LANES-1:0]   in_pi,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PO_PER_LANE*LANES-1:0]   out_po,
  input  logic                           cnt_clr,
  output logic [CNT_W-1:0]               cnt_po1
);

  localparam int unsigned PO_W  = PO_PER_LANE * LANES;
  localparam int unsigned SUM_W = CNT_W + 5;

  logic [PO_W-1:0]             w_lane_po;
  logic [DEPTH-1:0]            r_vld;
  logic [DEPTH-1:0][PO_W-1:0]  r_dat;
  logic [DEPTH:0]              w_rdy;
  logic [DEPTH-1:0]            w_src_vld;
  logic [DEPTH-1:0][PO_W-1:0]  w_src_dat;
  logic [CNT_W-1:0]            r_cnt;
  logic [SUM_W-1:0]            w_pop;
  logic [SUM_W-1:0]            w_sum;
  logic                        w_xfer;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    t5_lane u_lane (
      .i_pi   (lane_pi_t'(in_pi[k*PI_PER_LANE +: PI_PER_LANE])),
      .o_po_c (w_lane_po[k*PO_PER_LANE +: PO_PER_LANE])
    );
  end

  // Ready ripples back from the sink; an empty stage is always ready so bubbles collapse.
  always_comb begin
    w_rdy        = '0;
    w_rdy[DEPTH] = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      w_rdy[i] = ~r_vld[i] | w_rdy[i+1];
    end
  end

  assign in_ready = w_rdy[0];

  // Source of each stage: lane logic for stage 0, the previous stage otherwise.
  always_comb begin
    w_src_vld    = '0;
    w_src_dat    = '0;
    w_src_vld[0] = in_valid;
    w_src_dat[0] = w_lane_po;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      w_src_vld[i] = r_vld[i-1];
      w_src_dat[i] = r_dat[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_vld[i] <= w_src_vld[i];
          if (w_src_vld[i]) r_dat[i] <= w_src_dat[i];
        end
      end
    end
  end

  assign out_valid = r_vld[DEPTH-1];
  assign out_po    = r_dat[DEPTH-1];

  // Population count of po1 bits on the output beat, widened so saturation can be detected.
  always_comb begin
    w_pop = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_pop = w_pop + SUM_W'(out_po[k*PO_PER_LANE + 1]);
    end
    w_sum  = SUM_W'(r_cnt) + w_pop;
    w_xfer = out_valid & out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= (|w_sum[SUM_W-1:CNT_W]) ? '1 : w_sum[CNT_W-1:0];
    end
  end

  assign cnt_po1 = r_cnt;

endmodule

// File: tb/tb_t5_pipe.sv
// Scoreboard bench for t5_pipe: directed corner cases followed by randomized traffic.
module tb_t5_pipe;

  localparam int unsigned L     = 4;
  localparam int unsigned D     = 2;
  localparam int unsigned CW    = 8;
  localparam int          CMAX  = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [5*L-1:0]    in_pi;
  logic              out_valid;
  logic              out_ready;
  logic [2*L-1:0]    out_po;
  logic              cnt_clr;
  logic [CW-1:0]     cnt_po1;

  int n_vec = 0;
  int n_err = 0;
  int m_cnt = 0;
  logic [2*L-1:0] q[$];

  t5_pipe #(.LANES(L), .DEPTH(D), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pi     (in_pi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_po    (out_po),
    .cnt_clr   (cnt_clr),
    .cnt_po1   (cnt_po1)
  );

  always #5 clk = ~clk;

  // Reference: per lane po0/po1 from the boolean rules, packed lane-major.
  function automatic logic [2*L-1:0] ref_po(input logic [5*L-1:0] pi);
    logic [2*L-1:0] r;
    bit p0, p1, p2, p3, p4, n9;
    r = '0;
    for (int k = 0; k < int'(L); k++) begin
      p0 = pi[5*k];   p1 = pi[5*k+1]; p2 = pi[5*k+2];
      p3 = pi[5*k+3]; p4 = pi[5*k+4];
      n9 = p2 && p3;
      r[2*k]   = (p0 && p2) || (p1 && !n9);
      r[2*k+1] = !n9 && (p1 || p4);
    end
    return r;
  endfunction

  function automatic int po1_count(input logic [2*L-1:0] po);
    int c = 0;
    for (int k = 0; k < int'(L); k++) c += int'(po[2*k+1]);
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected beats on output transfer, tracks the counter, pushes accepted beats.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
    end else begin
      logic [2*L-1:0] exp;
      int             inc;
      inc = 0;
      chk("cnt_po1", 32'(cnt_po1), 32'(m_cnt));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %0h expected none at %0t", out_po, $time);
        end else begin
          exp = q.pop_front();
          chk("out_po", 32'(out_po), 32'(exp));
          inc = po1_count(exp);
        end
      end
      if (cnt_clr) m_cnt = 0;
      else m_cnt = (m_cnt + inc > CMAX) ? CMAX : m_cnt + inc;
      if (in_valid && in_ready) q.push_back(ref_po(in_pi));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Hold a beat on the input until accepted; called and returns at posedge+1.
  task automatic drive_beat(input logic [5*L-1:0] pi);
    in_valid = 1'b1;
    in_pi    = pi;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL accept_timeout: got no in_ready expected acceptance at %0t", $time);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [5*L-1:0] a, b, c;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pi     = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;

    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_po",    32'(out_po),    32'd0);
    chk("rst_cnt",       32'(cnt_po1),   32'd0);
    idle(2);
    rst_n = 1'b1;

    // Single beat, latency and value.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pi     = 20'h141C5;
    @(negedge clk); chk("first_accept", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    @(negedge clk); chk("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_cycle2", 32'(out_valid), 32'd1);
    chk("po_E1", 32'(out_po), 32'hE1);
    @(negedge clk); chk("cnt_after_E1", 32'(cnt_po1), 32'd2);
    step();
    idle(3);

    // Backpressure: capacity DEPTH, then drain in order.
    a = 20'($urandom); b = 20'($urandom); c = 20'($urandom);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pi     = a;
    @(negedge clk); chk("bp_rdy_a", 32'(in_ready), 32'd1);
    step(); in_pi = b;
    @(negedge clk); chk("bp_rdy_b", 32'(in_ready), 32'd1);
    step(); in_pi = c;
    @(negedge clk); chk("bp_rdy_c", 32'(in_ready), 32'd0);
    step();
    @(negedge clk); chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    chk("bp_full_vld", 32'(out_valid), 32'd1);
    step(); out_ready = 1'b1;
    drive_beat(c);
    idle(4);

    // Clear coinciding with a transfer of three po1 bits on a count of five.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    drive_beat(20'h10842);
    drive_beat(20'h00002);
    idle(4);
    @(negedge clk); chk("cnt_five", 32'(cnt_po1), 32'd5);
    step();
    out_ready = 1'b0;
    drive_beat(20'h00842);
    idle(3);
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    @(negedge clk); chk("clr_xfer_vld", 32'(out_valid), 32'd1);
    step(); cnt_clr = 1'b0;
    @(negedge clk); chk("clr_discard", 32'(cnt_po1), 32'd0);
    step();

    // Saturation: 70 beats of four po1 bits each.
    for (int i = 0; i < 70; i++) drive_beat(20'h10842);
    idle(4);
    @(negedge clk); chk("cnt_saturate", 32'(cnt_po1), 32'(CMAX));
    step();

    // Asynchronous reset with two beats in flight.
    out_ready = 1'b0;
    drive_beat(20'($urandom));
    drive_beat(20'($urandom));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_out_po",    32'(out_po),    32'd0);
    chk("arst_cnt",       32'(cnt_po1),   32'd0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); chk("no_beat_after_rst", 32'(out_valid), 32'd0);
    end
    step();

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pi     = 20'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 40) == 0);
      step();
    end
    in_valid  = 1'b0;
    cnt_clr   = 1'b0;
    out_ready = 1'b1;
    idle(10);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
